// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the systemizer phase sequencer: state encoding and
// derived-width helpers used by the interface, the top and the range generator.
package phase_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIV_ISSUE,
        S_PIV_WAIT,
        S_ELIM_ISSUE,
        S_ELIM_WAIT,
        S_DRAIN,
        S_REDO,
        S_FINISH
    } seq_state_e;

    // Never return 0 so a degenerate parameter set still yields a legal vector.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned blk_w(input int unsigned n, input int unsigned l,
                                          input int unsigned k);
        return clog2_min1(l * k / n + 1);
    endfunction

    function automatic int unsigned ph_w(input int unsigned n, input int unsigned l);
        return clog2_min1(l / n + 1);
    endfunction

    function automatic int unsigned rt_w(input int unsigned max_retry);
        return clog2_min1(max_retry + 1);
    endfunction

    function automatic int unsigned rows_w(input int unsigned l);
        return $clog2(l) + 1;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Host and phase-engine handshake bundle of the phase sequencer.
// master = the sequencer itself, slave = host/engine side.
interface phase_sequencer_if
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned L         = 12,
    parameter int unsigned K         = 24,
    parameter int unsigned MAX_RETRY = 3
);
    localparam int unsigned BLK_W = blk_w(N, L, K);
    localparam int unsigned PH_W  = ph_w(N, L);
    localparam int unsigned RT_W  = rt_w(MAX_RETRY);
    localparam int unsigned ROW_W = rows_w(L);

    logic             start;
    logic             abort;
    logic             done;
    logic             success;
    logic [RT_W-1:0]  retry_cnt;
    logic             redo_req;
    logic             redo_ack;
    logic             ph_start;
    logic             ph_pivot;
    logic [PH_W-1:0]  ph_phase;
    logic [BLK_W-1:0] ph_start_block;
    logic [BLK_W-1:0] ph_end_block;
    logic [ROW_W-1:0] ph_rows;
    logic             ph_done;
    logic             ph_fail;

    modport master (
        input  start, abort, redo_ack, ph_done, ph_fail,
        output done, success, retry_cnt, redo_req,
               ph_start, ph_pivot, ph_phase, ph_start_block, ph_end_block, ph_rows
    );

    modport slave (
        output start, abort, redo_ack, ph_done, ph_fail,
        input  done, success, retry_cnt, redo_req,
               ph_start, ph_pivot, ph_phase, ph_start_block, ph_end_block, ph_rows
    );

endinterface

// File: rtl/phase_sequencer_elim_range_gen.sv
// Word range of one elimination step: column blocks c .. c+ELIM_SPAN-1 with
// c = p+1+chunk*ELIM_SPAN, clipped to the last column block of the matrix.
module elim_range_gen
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned L         = 12,
    parameter int unsigned K         = 24,
    parameter int unsigned ELIM_SPAN = 6,
    localparam int unsigned BLK_W    = blk_w(N, L, K),
    localparam int unsigned PH_W     = ph_w(N, L)
) (
    input  logic [PH_W-1:0]  i_p,
    input  logic [BLK_W-1:0] i_chunk,
    output logic [BLK_W-1:0] o_start_block,
    output logic [BLK_W-1:0] o_end_block,
    output logic             o_last,
    output logic             o_none
);
    localparam int unsigned NB = K / N;

    logic [31:0] w_c;
    logic [31:0] w_c_lo;
    logic [31:0] w_c_hi;

    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        w_c    = 32'(i_p) + 32'd1 + 32'(i_chunk) * ELIM_SPAN;
        w_c_lo = (w_c > NB) ? NB : w_c;
        w_c_hi = (w_c + ELIM_SPAN > NB) ? NB : w_c + ELIM_SPAN;

        o_start_block = BLK_W'(w_c_lo * L);
        o_end_block   = BLK_W'(w_c_hi * L - 32'd1);
        o_last        = (w_c + ELIM_SPAN >= NB);
        o_none        = (32'(i_p) + 32'd1 >= NB);
    end

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: drives a phase engine through pivot/elimination steps of a
// matrix systemization, with bounded redo on pivot failure and host abort.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned L         = 12,
    parameter int unsigned K         = 24,
    parameter int unsigned ELIM_SPAN = 6,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    phase_sequencer_if.master bus
);
    localparam int unsigned BLK_W  = blk_w(N, L, K);
    localparam int unsigned PH_W   = ph_w(N, L);
    localparam int unsigned RT_W   = rt_w(MAX_RETRY);
    localparam int unsigned ROW_W  = rows_w(L);
    localparam int unsigned LAST_P = L / N - 1;

    seq_state_e       r_state, w_state_nxt;
    logic [PH_W-1:0]  r_p, w_p_nxt;
    logic [BLK_W-1:0] r_chunk, w_chunk_nxt;
    logic [RT_W-1:0]  r_retry, w_retry_nxt;
    logic             r_success, w_success_nxt;
    logic             r_fail, w_fail_nxt;
    logic             r_abort, w_abort_nxt;

    logic [BLK_W-1:0] w_elim_start, w_elim_end;
    logic             w_elim_last, w_elim_none;
    logic             w_abort_any, w_phase_end;
    logic [BLK_W-1:0] w_start_block, w_end_block;

    elim_range_gen #(
        .N(N), .L(L), .K(K), .ELIM_SPAN(ELIM_SPAN)
    ) u_range (
        .i_p           (r_p),
        .i_chunk       (r_chunk),
        .o_start_block (w_elim_start),
        .o_end_block   (w_elim_end),
        .o_last        (w_elim_last),
        .o_none        (w_elim_none)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_p       <= '0;
            r_chunk   <= '0;
            r_retry   <= '0;
            r_success <= 1'b0;
            r_fail    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_p       <= w_p_nxt;
            r_chunk   <= w_chunk_nxt;
            r_retry   <= w_retry_nxt;
            r_success <= w_success_nxt;
            r_fail    <= w_fail_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_p_nxt       = r_p;
        w_chunk_nxt   = r_chunk;
        w_retry_nxt   = r_retry;
        w_success_nxt = r_success;
        w_fail_nxt    = r_fail;
        w_abort_nxt   = r_abort;
        w_phase_end   = 1'b0;
        w_abort_any   = r_abort | bus.abort;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt   = S_PIV_ISSUE;
                    w_p_nxt       = '0;
                    w_retry_nxt   = '0;
                    w_success_nxt = 1'b0;
                    w_fail_nxt    = 1'b0;
                    w_abort_nxt   = 1'b0;
                end
            end
            // An abort during issue still has a ph_done outstanding; remember it.
            S_PIV_ISSUE: begin
                w_state_nxt = S_PIV_WAIT;
                w_abort_nxt = w_abort_any;
            end
            S_PIV_WAIT: begin
                w_abort_nxt = w_abort_any;
                w_fail_nxt  = r_fail | bus.ph_fail;
                if (bus.ph_done) begin
                    if (w_abort_any) begin
                        w_state_nxt = S_FINISH;
                    end else if (w_fail_nxt) begin
                        w_state_nxt = S_DRAIN;
                    end else if (w_elim_none) begin
                        w_phase_end = 1'b1;
                    end else begin
                        w_state_nxt = S_ELIM_ISSUE;
                        w_chunk_nxt = '0;
                    end
                end
            end
            S_ELIM_ISSUE: begin
                w_state_nxt = S_ELIM_WAIT;
                w_abort_nxt = w_abort_any;
            end
            S_ELIM_WAIT: begin
                w_abort_nxt = w_abort_any;
                if (bus.ph_done) begin
                    if (w_abort_any) begin
                        w_state_nxt = S_FINISH;
                    end else if (w_elim_last) begin
                        w_phase_end = 1'b1;
                    end else begin
                        w_state_nxt = S_ELIM_ISSUE;
                        w_chunk_nxt = r_chunk + BLK_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (w_abort_any || r_retry == RT_W'(MAX_RETRY)) w_state_nxt = S_FINISH;
                else                                             w_state_nxt = S_REDO;
            end
            S_REDO: begin
                if (w_abort_any) begin
                    w_state_nxt = S_FINISH;
                end else if (bus.redo_ack) begin
                    w_state_nxt = S_PIV_ISSUE;
                    w_retry_nxt = r_retry + RT_W'(1);
                    w_p_nxt     = '0;
                    w_fail_nxt  = 1'b0;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        if (w_phase_end) begin
            if (r_p == PH_W'(LAST_P)) begin
                w_state_nxt   = S_FINISH;
                w_success_nxt = 1'b1;
            end else begin
                w_state_nxt = S_PIV_ISSUE;
                w_p_nxt     = r_p + PH_W'(1);
            end
        end
    end

    // Ranges are only meaningful while a step is issued or outstanding.
    always_comb begin
        w_start_block = '0;
        w_end_block   = '0;
        if (r_state == S_PIV_ISSUE || r_state == S_PIV_WAIT) begin
            w_start_block = BLK_W'(r_p) * BLK_W'(L);
            w_end_block   = BLK_W'(r_p) * BLK_W'(L) + BLK_W'(L - 1);
        end else if (r_state == S_ELIM_ISSUE || r_state == S_ELIM_WAIT) begin
            w_start_block = w_elim_start;
            w_end_block   = w_elim_end;
        end
    end

    assign bus.ph_start       = (r_state == S_PIV_ISSUE) || (r_state == S_ELIM_ISSUE);
    assign bus.ph_pivot       = (r_state == S_PIV_ISSUE) || (r_state == S_PIV_WAIT);
    assign bus.done           = (r_state == S_FINISH);
    assign bus.redo_req       = (r_state == S_REDO);
    assign bus.success        = r_success;
    assign bus.retry_cnt      = r_retry;
    assign bus.ph_phase       = r_p;
    assign bus.ph_start_block = w_start_block;
    assign bus.ph_end_block   = w_end_block;
    assign bus.ph_rows        = ROW_W'(L) - ROW_W'(r_p) * ROW_W'(N);

endmodule
